// File: rtl/decode_dispatch_ctrl_pkg.sv
// Purpose: shared types and constants for the decode/dispatch path (also used by ROB and LSQ).
// Latency: n/a (types only).
// Backpressure: n/a.
package decode_dispatch_ctrl_pkg;

  localparam int N_WAY    = 2;   // instructions per bundle
  localparam int XLEN     = 32;  // PC / instruction width
  localparam int REG_BITS = 5;   // architectural register index width
  localparam int CNT_BITS = 5;   // free-entry count width

  localparam int SEL_BITS = (N_WAY > 1) ? $clog2(N_WAY) : 1;
  localparam int K_BITS   = $clog2(N_WAY + 1);

  localparam logic [1:0] LDST_NONE  = 2'b00;
  localparam logic [1:0] LDST_LOAD  = 2'b10;
  localparam logic [1:0] LDST_STORE = 2'b01;

  typedef struct packed {
    logic is_branch;
    logic halt;
    logic illegal;
  } disp_flags_t;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     inst;
    logic [REG_BITS-1:0] src1;
    logic [REG_BITS-1:0] src2;
    logic [REG_BITS-1:0] dest;
    disp_flags_t         flags;
    logic [1:0]          ld_st;
  } disp_slot_t;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } disp_state_e;

endpackage

// File: rtl/decode_dispatch_ctrl_slot_select.sv
// Purpose: picks how many pending slots dispatch this cycle and which buffer slot feeds each lane.
// Latency: purely combinational.
// Backpressure: stops at the first slot that does not fit in ROB/RS/LSQ free space.
// Ports: pending/stop_mask/mem_mask per buffer slot; rob/rs/lsq free counts;
//        k = slots dispatched, lane_sel = buffer index per lane, disp_mask = buffer slots taken,
//        halt_hit = a halt/illegal slot was among those taken.
module disp_slot_select
  import decode_dispatch_ctrl_pkg::*;
(
  input  logic [N_WAY-1:0]                pending,
  input  logic [N_WAY-1:0]                stop_mask,
  input  logic [N_WAY-1:0]                mem_mask,
  input  logic [CNT_BITS-1:0]             rob_free,
  input  logic [CNT_BITS-1:0]             rs_free,
  input  logic [CNT_BITS-1:0]             lsq_free,
  output logic [K_BITS-1:0]               k,
  output logic [N_WAY-1:0][SEL_BITS-1:0]  lane_sel,
  output logic [N_WAY-1:0]                disp_mask,
  output logic                            halt_hit
);

  localparam logic [CNT_BITS:0] NEED_ONE = (CNT_BITS+1)'(1);

  always_comb begin
    logic            walking;
    logic [CNT_BITS:0] rob_need;
    logic [CNT_BITS:0] rs_need;
    logic [CNT_BITS:0] lsq_need;
    int              cnt;
    k         = '0;
    lane_sel  = '0;
    disp_mask = '0;
    halt_hit  = 1'b0;
    walking   = 1'b1;
    rob_need  = '0;
    rs_need   = '0;
    lsq_need  = '0;
    cnt       = 0;
    for (int i = 0; i < N_WAY; i++) begin
      if (walking && pending[i]) begin
        // Cumulative need is one wider than the counts, so large counts saturate naturally.
        rob_need = rob_need + NEED_ONE;
        if (!stop_mask[i]) rs_need  = rs_need + NEED_ONE;
        if (mem_mask[i])   lsq_need = lsq_need + NEED_ONE;
        if ((rob_need > {1'b0, rob_free}) || (rs_need > {1'b0, rs_free}) ||
            (lsq_need > {1'b0, lsq_free})) begin
          walking = 1'b0;
        end else begin
          for (int j = 0; j < N_WAY; j++) begin
            if (j == cnt) lane_sel[j] = SEL_BITS'(i);
          end
          disp_mask[i] = 1'b1;
          cnt = cnt + 1;
          // A halt/illegal slot goes out but nothing younger may follow it.
          if (stop_mask[i]) begin
            halt_hit = 1'b1;
            walking  = 1'b0;
          end
        end
      end
    end
    k = K_BITS'(cnt);
  end

endmodule

// File: rtl/decode_dispatch_ctrl.sv
// Purpose: buffers one decoded bundle and dispatches its slots in order into ROB/RS/LSQ.
// Latency: 1 cycle from accept to first dispatch (no bypass).
// Backpressure: dec_ready drops while a remainder is held or after halt; squash clears all.
// Ports: clock/reset (async, active-low); squash; dec_* bundle from decoder; rob/rs/lsq free
//        counts; dec_ready; disp_* lanes (disp_valid is a contiguous prefix); halted (sticky).
module decode_dispatch_ctrl
  import decode_dispatch_ctrl_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic [N_WAY-1:0]          dec_valid,
  input  logic [N_WAY*XLEN-1:0]     dec_PC,
  input  logic [N_WAY*XLEN-1:0]     dec_inst,
  input  logic [N_WAY*REG_BITS-1:0] dec_src1,
  input  logic [N_WAY*REG_BITS-1:0] dec_src2,
  input  logic [N_WAY*REG_BITS-1:0] dec_dest,
  input  logic [N_WAY-1:0]          dec_is_branch,
  input  logic [N_WAY-1:0]          dec_halt,
  input  logic [N_WAY-1:0]          dec_illegal,
  input  logic [N_WAY*2-1:0]        dec_ld_st,
  input  logic [CNT_BITS-1:0]       rob_free,
  input  logic [CNT_BITS-1:0]       rs_free,
  input  logic [CNT_BITS-1:0]       lsq_free,
  output logic                      dec_ready,
  output logic [N_WAY-1:0]          disp_valid,
  output logic [N_WAY*XLEN-1:0]     disp_PC,
  output logic [N_WAY*XLEN-1:0]     disp_inst,
  output logic [N_WAY*REG_BITS-1:0] disp_src1,
  output logic [N_WAY*REG_BITS-1:0] disp_src2,
  output logic [N_WAY*REG_BITS-1:0] disp_dest,
  output logic [N_WAY-1:0]          disp_is_branch,
  output logic [N_WAY*2-1:0]        disp_ld_st,
  output logic [N_WAY-1:0]          disp_halt,
  output logic [N_WAY-1:0]          disp_illegal,
  output logic                      halted
);

  disp_state_e state_q, state_d;
  logic [N_WAY-1:0] pending_q, pending_d;
  disp_slot_t buf_q [N_WAY];
  disp_slot_t buf_d [N_WAY];

  disp_slot_t dec_slot [N_WAY];
  disp_slot_t load_buf [N_WAY];
  logic [N_WAY-1:0] load_pending;
  logic [N_WAY-1:0] stop_mask, mem_mask;
  logic [K_BITS-1:0] k;
  logic [N_WAY-1:0][SEL_BITS-1:0] lane_sel;
  logic [N_WAY-1:0] disp_mask, fire_mask, pending_after, lane_mask;
  logic halt_hit, halt_fire, disp_active, accept;

  always_comb begin
    for (int i = 0; i < N_WAY; i++) begin
      dec_slot[i].pc              = dec_PC[i*XLEN +: XLEN];
      dec_slot[i].inst            = dec_inst[i*XLEN +: XLEN];
      dec_slot[i].src1            = dec_src1[i*REG_BITS +: REG_BITS];
      dec_slot[i].src2            = dec_src2[i*REG_BITS +: REG_BITS];
      dec_slot[i].dest            = dec_dest[i*REG_BITS +: REG_BITS];
      dec_slot[i].flags.is_branch = dec_is_branch[i];
      dec_slot[i].flags.halt      = dec_halt[i];
      dec_slot[i].flags.illegal   = dec_illegal[i];
      dec_slot[i].ld_st           = dec_ld_st[i*2 +: 2];
    end
  end

  // Squeeze invalid decoder slots out so the buffer always holds a dense, ordered prefix.
  always_comb begin
    int pos;
    pos = 0;
    for (int i = 0; i < N_WAY; i++) load_buf[i] = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (dec_valid[i]) begin
        for (int j = 0; j < N_WAY; j++) begin
          if (j == pos) load_buf[j] = dec_slot[i];
        end
        pos = pos + 1;
      end
    end
    for (int j = 0; j < N_WAY; j++) load_pending[j] = (j < pos);
  end

  always_comb begin
    for (int i = 0; i < N_WAY; i++) begin
      stop_mask[i] = buf_q[i].flags.halt | buf_q[i].flags.illegal;
      mem_mask[i]  = (buf_q[i].ld_st != LDST_NONE);
    end
  end

  disp_slot_select u_sel (
    .pending   (pending_q),
    .stop_mask (stop_mask),
    .mem_mask  (mem_mask),
    .rob_free  (rob_free),
    .rs_free   (rs_free),
    .lsq_free  (lsq_free),
    .k         (k),
    .lane_sel  (lane_sel),
    .disp_mask (disp_mask),
    .halt_hit  (halt_hit)
  );

  assign disp_active   = (state_q == ST_HOLD) && !squash;
  assign fire_mask     = disp_active ? disp_mask : '0;
  assign halt_fire     = disp_active && halt_hit;
  assign pending_after = pending_q & ~fire_mask;
  assign lane_mask     = N_WAY'((1 << k) - 1);
  assign disp_valid    = disp_active ? lane_mask : '0;
  assign halted        = (state_q == ST_HALTED);
  assign accept        = dec_ready && (|dec_valid) && !squash;

  always_comb begin
    dec_ready = 1'b0;
    unique case (state_q)
      ST_EMPTY:  dec_ready = 1'b1;
      ST_HOLD:   dec_ready = disp_active && (pending_after == '0) && !halt_hit;
      ST_HALTED: dec_ready = 1'b0;
      default:   dec_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    buf_d     = buf_q;
    if (squash) begin
      state_d   = ST_EMPTY;
      pending_d = '0;
      for (int i = 0; i < N_WAY; i++) buf_d[i] = '0;
    end else begin
      if (state_q == ST_HOLD) begin
        pending_d = pending_after;
        if (halt_fire) begin
          // Younger slots behind a halt/illegal are discarded.
          state_d   = ST_HALTED;
          pending_d = '0;
        end else if (pending_after == '0) begin
          state_d = ST_EMPTY;
        end
      end
      if (accept) begin
        state_d   = ST_HOLD;
        pending_d = load_pending;
        buf_d     = load_buf;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_EMPTY;
      pending_q <= '0;
      for (int i = 0; i < N_WAY; i++) buf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      buf_q     <= buf_d;
    end
  end

  for (genvar j = 0; j < N_WAY; j++) begin : g_lane
    disp_slot_t s;
    assign s = buf_q[lane_sel[j]];
    assign disp_PC[j*XLEN +: XLEN]           = s.pc;
    assign disp_inst[j*XLEN +: XLEN]         = s.inst;
    assign disp_src1[j*REG_BITS +: REG_BITS] = s.src1;
    assign disp_src2[j*REG_BITS +: REG_BITS] = s.src2;
    assign disp_dest[j*REG_BITS +: REG_BITS] = s.dest;
    assign disp_is_branch[j]                 = s.flags.is_branch;
    assign disp_ld_st[j*2 +: 2]              = s.ld_st;
    assign disp_halt[j]    = disp_valid[j] & (s.flags.halt | s.flags.illegal);
    assign disp_illegal[j] = disp_valid[j] & s.flags.illegal;
  end

endmodule

// File: doc/decode_dispatch_ctrl.md
Name: decode_dispatch_ctrl

Overview:
- Sequences the N_WAY bundle produced by the combinational instruction decoder into the ROB, reservation station (RS) and LSQ.
- Registers one decoded bundle and dispatches its slots strictly in program order, as far as free ROB, RS and LSQ entries allow.
- Holds any undispatched remainder and back-pressures fetch/decode.
- Stops dispatch after a halt or illegal instruction; a squash clears all held state.

Parameters:
N_WAY, 2, instructions per bundle (matches decoder width)
XLEN, 32, PC/instruction width
REG_BITS, 5, architectural register index width
CNT_BITS, 5, width of free-entry counts

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
squash  in  1  branch mispredict/flush; clears all held state
dec_valid  in  N_WAY  per-slot valid from decoder
dec_PC  in  N_WAY*XLEN  slot PC
dec_inst  in  N_WAY*XLEN  slot instruction word
dec_src1, dec_src2, dec_dest  in  N_WAY*REG_BITS each  register indices (0 = none)
dec_is_branch, dec_halt, dec_illegal  in  N_WAY each  decoder flags
dec_ld_st  in  N_WAY*2  2'b10 load, 2'b01 store, 0 other
rob_free, rs_free, lsq_free  in  CNT_BITS each  free entries this cycle
dec_ready  out  1  bundle accepted when dec_ready and any dec_valid
disp_valid  out  N_WAY  dispatched slots; always a contiguous prefix from bit 0
disp_PC, disp_inst, disp_src1, disp_src2, disp_dest, disp_is_branch, disp_ld_st  out  per-slot  fields of dispatched instructions, oldest first
disp_halt  out  N_WAY  slot is a halt or an illegal instruction
disp_illegal  out  N_WAY  slot is an illegal instruction
halted  out  1  sticky: halt/illegal dispatched, dispatch stopped

Behaviour:
- Reset (reset=0, asynchronous):
  - buffer empty, pending mask 0, state EMPTY.
  - halted=0, disp_valid=0.
  - dec_ready=1 once reset deasserts.
- States:
  - EMPTY: no pending slots.
  - HOLD: buffer has pending slots.
  - HALTED: dispatch stopped.
- Accept:
  - On clock edge with dec_ready=1 and any dec_valid: load the bundle; pending = dec_valid.
  - Invalid slots inside a bundle are compressed out, preserving order.
  - Dispatch from a newly loaded bundle begins the next cycle (1-cycle latency; no decode-to-dispatch bypass).
- Dispatch (combinational from buffer and free counts):
  - Walk pending slots oldest-first.
  - Each slot needs 1 ROB entry.
  - Non-halt/non-illegal slots also need 1 RS entry.
  - Slots with dec_ld_st != 0 also need 1 LSQ entry.
  - Stop at the first slot whose cumulative need exceeds rob_free, rs_free or lsq_free. Never skip a slot.
  - A halt/illegal slot is dispatched and ends the walk. Younger slots in that bundle are dropped.
- Output packing:
  - disp_valid = (1<<k)-1, where k = number of slots dispatched this cycle.
  - disp lane j carries the j-th oldest pending slot.
- Pending update:
  - Dispatched slots clear from pending.
  - Pending empties → EMPTY, unless halt/illegal was dispatched → HALTED with halted=1.
- dec_ready:
  - 1 in EMPTY.
  - In HOLD, 1 iff every pending slot dispatches this cycle and none is halt/illegal. A new bundle then loads on the same edge.
  - 0 in HALTED.
- HALTED: disp_valid=0; dec_valid ignored; exited only by squash or reset.
- squash:
  - Next edge clears the buffer, pending and halted; state → EMPTY.
  - Dominates accept: a same-cycle bundle is not loaded.
  - disp_valid is forced to 0 in the squash cycle.
- Free counts saturate logically: counts ≥ N_WAY never limit dispatch.
- Zero free ROB entries → k=0 and the bundle is held unchanged.
- All-zero dec_valid with dec_ready=1 → no load; state unchanged.

Decomposition:
- Shared package: DISP_SLOT struct (PC, inst, src1, src2, dest, flags, ld_st) and the LD/ST encoding constants 2'b10/2'b01. These are reused by the ROB and LSQ.
- One natural sub-module: disp_slot_select. It is purely combinational: pending mask, slot flags and free counts in; k and the per-lane mux selects out.
- The state register, bundle buffer and pending mask live in the top module.

Test Plan:
1. Full dispatch (N_WAY=2): two ADDs valid, all free counts=8 → accepted cycle 0; cycle 1 disp_valid=2'b11, lanes in PC order; dec_ready=1 throughout.
2. Partial dispatch: two ADDs, rob_free=1 → cycle 1 disp_valid=01 (older) and dec_ready=0; raise rob_free=4 → cycle 2 disp_valid=01 carries the younger slot; dec_ready=1.
3. LSQ limit: slot0 LW, slot1 SW, lsq_free=1, others 8 → disp_valid=01; slot1 held until lsq_free≥1.
4. Halt mid-bundle: slot0 WFI, slot1 ADD → disp_valid=01 with disp_halt[0]=1; halted=1 next cycle; slot1 never dispatched; dec_ready=0; new dec_valid ignored.
5. Squash: in HOLD with a pending slot, squash=1 while dec_valid=11 → disp_valid=0; next cycle EMPTY with nothing loaded; halted cleared; dec_ready=1.
6. Async reset: reset=0 mid-HOLD, between clock edges → disp_valid=0 and halted=0 immediately; pending cleared; after reset=1, dec_ready=1.
